// File: rtl/instruction_fetch_unit_if.sv
// instruction_fetch_unit_if: instruction-memory read bus (req/addr out, data/ready back)
//  Ports/signals: imem_req, imem_addr[PC_W], imem_data[INSTR_W], imem_ready
//  Modports: master (fetch unit side), slave (memory side)
interface instruction_fetch_unit_if #(
    parameter int PC_W    = 10,
    parameter int INSTR_W = 32
);
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_data;
    logic               imem_ready;
    modport master(output imem_req, imem_addr, input imem_data, imem_ready);
    modport slave(input imem_req, imem_addr, output imem_data, imem_ready);
endinterface

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: IF stage feeding the IF/ID latch with {instruction, PC+1}
//  Ports: enable (clock, rising edge), reset (sync, active-high),
//         PC_write_i (1 = advance, 0 = stall), branch_taken_i / branch_target_i (redirect),
//         imem (instruction memory bus, master side),
//         instruc_out_o / PC_plus_1_out_o / IF_ID_write_o (IF/ID latch write), halted_o.
//  Optional feature: define FETCH_HALT_EN to stop fetching after delivering a HALT_OPCODE word.
module instruction_fetch_unit #(
    parameter int              PC_W        = 10,
    parameter int              INSTR_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC    = '0,
    parameter logic [5:0]      HALT_OPCODE = 6'h3F
) (
    input  logic                     enable,
    input  logic                     reset,
    input  logic                     PC_write_i,
    input  logic                     branch_taken_i,
    input  logic [PC_W-1:0]          branch_target_i,
    instruction_fetch_unit_if.master imem,
    output logic [INSTR_W-1:0]       instruc_out_o,
    output logic [PC_W-1:0]          PC_plus_1_out_o,
    output logic                     IF_ID_write_o,
    output logic                     halted_o
);
    typedef enum logic [1:0] {
        IDLE,
        FETCH,
`ifdef FETCH_HALT_EN
        HOLD,
        HALT
`else
        HOLD
`endif
    } state_t;

    state_t             state_q;
    logic [PC_W-1:0]    pc_q;
    logic [PC_W-1:0]    pc_inc;
    logic [INSTR_W-1:0] buf_q;
    logic [INSTR_W-1:0] instr_q;
    logic [PC_W-1:0]    pcp1_q;
    logic               wr_q;
    logic [INSTR_W-1:0] dlv_data;
    logic               dlv;
    logic               flush;

    assign imem.imem_req  = state_q == FETCH;
    assign imem.imem_addr = pc_q;
    assign pc_inc         = pc_q + 1'b1;
    // A held word comes from the buffer, a fresh one straight off the bus.
    assign dlv_data       = state_q == HOLD ? buf_q : imem.imem_data;
    // Redirect beats delivery, so dlv already excludes the flush case.
    assign flush          = branch_taken_i && (state_q == FETCH || state_q == HOLD);
    assign dlv            = !branch_taken_i && PC_write_i &&
                            ((state_q == FETCH && imem.imem_ready) || state_q == HOLD);

    assign instruc_out_o   = instr_q;
    assign PC_plus_1_out_o = pcp1_q;
    assign IF_ID_write_o   = wr_q;

`ifdef FETCH_HALT_EN
    logic halted_q;
    logic is_halt;
    assign is_halt  = dlv_data[INSTR_W-1 -: 6] == HALT_OPCODE;
    assign halted_o = halted_q;
`else
    logic unused_halt_opcode;
    assign unused_halt_opcode = ^HALT_OPCODE;
    assign halted_o = 1'b0;
`endif

    always_ff @(posedge enable) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            buf_q   <= '0;
            instr_q <= '0;
            pcp1_q  <= '0;
            wr_q    <= 1'b0;
`ifdef FETCH_HALT_EN
            halted_q <= 1'b0;
`endif
        end else begin
            wr_q <= flush || dlv;
            if (flush) begin
                pc_q    <= branch_target_i;
                instr_q <= '0;
                pcp1_q  <= branch_target_i;
                state_q <= FETCH;
            end else if (dlv) begin
                instr_q <= dlv_data;
                pcp1_q  <= pc_inc;
                pc_q    <= pc_inc;
`ifdef FETCH_HALT_EN
                state_q  <= is_halt ? HALT : FETCH;
                halted_q <= is_halt;
`else
                state_q <= FETCH;
`endif
            end else begin
                case (state_q)
                    IDLE: begin
                        if (branch_taken_i) pc_q <= branch_target_i;
                        state_q <= FETCH;
                    end
                    FETCH: begin
                        if (imem.imem_ready) begin
                            buf_q   <= imem.imem_data;
                            state_q <= HOLD;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed bench for instruction_fetch_unit
module tb_instruction_fetch_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        pc_write;
    logic        br;
    logic [9:0]  br_tgt;
    logic [31:0] instr;
    logic [9:0]  pcp1;
    logic        wr;
    logic        halted;
    int          lat = 0;
    int          cnt = 0;
    logic        force_rdy = 1'b0;
    logic        halt_on = 1'b0;
    int          compared = 0;
    int          mismatched = 0;

    instruction_fetch_unit_if #(.PC_W(10), .INSTR_W(32)) bus();

    instruction_fetch_unit dut (
        .enable(clk), .reset(rst), .PC_write_i(pc_write), .branch_taken_i(br),
        .branch_target_i(br_tgt), .imem(bus), .instruc_out_o(instr),
        .PC_plus_1_out_o(pcp1), .IF_ID_write_o(wr), .halted_o(halted)
    );

    always #5 clk = ~clk;

    always_comb begin
        bus.imem_ready = force_rdy || (bus.imem_req && cnt >= lat);
        bus.imem_data  = (halt_on && bus.imem_addr == 10'd3) ? 32'hFC00_0000
                                                             : {22'b0, bus.imem_addr} + 32'h100;
    end

    always @(posedge clk) cnt <= (bus.imem_req && !bus.imem_ready) ? cnt + 1 : 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; pc_write = 1'b1; br = 1'b0; br_tgt = '0;
        tick(); tick();
        compared++; if (instr !== 32'h0) begin mismatched++; $display("FAIL reset_instr got %h want 0", instr); end
        compared++; if (pcp1 !== 10'h0) begin mismatched++; $display("FAIL reset_pcp1 got %h want 0", pcp1); end
        compared++; if (wr !== 1'b0) begin mismatched++; $display("FAIL reset_wr got %b want 0", wr); end
        compared++; if (halted !== 1'b0) begin mismatched++; $display("FAIL reset_halted got %b want 0", halted); end
        compared++; if (bus.imem_req !== 1'b0) begin mismatched++; $display("FAIL reset_req got %b want 0", bus.imem_req); end
        rst = 1'b0; force_rdy = 1'b1;
        tick();
        force_rdy = 1'b0;
        compared++; if (wr !== 1'b0) begin mismatched++; $display("FAIL idle_ready_ignored got %b want 0", wr); end
        compared++; if (bus.imem_req !== 1'b1) begin mismatched++; $display("FAIL fetch_req got %b want 1", bus.imem_req); end
        compared++; if (bus.imem_addr !== 10'h0) begin mismatched++; $display("FAIL fetch_addr got %h want 0", bus.imem_addr); end
    endtask

    task automatic test_stream();
        for (int i = 0; i < 4; i++) begin
            tick();
            compared++; if (instr !== 32'h100 + i) begin mismatched++; $display("FAIL stream_instr%0d got %h want %h", i, instr, 32'h100 + i); end
            compared++; if (pcp1 !== 10'(i + 1)) begin mismatched++; $display("FAIL stream_pcp1%0d got %h want %h", i, pcp1, i + 1); end
            compared++; if (wr !== 1'b1) begin mismatched++; $display("FAIL stream_wr%0d got %b want 1", i, wr); end
        end
    endtask

    task automatic test_slow_mem();
        lat = 3;
        for (int i = 0; i < 3; i++) begin
            tick();
            compared++; if (bus.imem_addr !== 10'h4) begin mismatched++; $display("FAIL slow_addr%0d got %h want 4", i, bus.imem_addr); end
            compared++; if (wr !== 1'b0) begin mismatched++; $display("FAIL slow_wr%0d got %b want 0", i, wr); end
        end
        tick();
        compared++; if (instr !== 32'h104) begin mismatched++; $display("FAIL slow_instr got %h want 104", instr); end
        compared++; if (pcp1 !== 10'h5) begin mismatched++; $display("FAIL slow_pcp1 got %h want 5", pcp1); end
        compared++; if (wr !== 1'b1) begin mismatched++; $display("FAIL slow_wr got %b want 1", wr); end
        lat = 0;
    endtask

    task automatic test_stall();
        pc_write = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            compared++; if (wr !== 1'b0) begin mismatched++; $display("FAIL stall_wr%0d got %b want 0", i, wr); end
            compared++; if (bus.imem_req !== 1'b0) begin mismatched++; $display("FAIL stall_req%0d got %b want 0", i, bus.imem_req); end
            compared++; if (bus.imem_addr !== 10'h5) begin mismatched++; $display("FAIL stall_pc%0d got %h want 5", i, bus.imem_addr); end
        end
        pc_write = 1'b1;
        tick();
        compared++; if (instr !== 32'h105) begin mismatched++; $display("FAIL release_instr got %h want 105", instr); end
        compared++; if (pcp1 !== 10'h6) begin mismatched++; $display("FAIL release_pcp1 got %h want 6", pcp1); end
        compared++; if (wr !== 1'b1) begin mismatched++; $display("FAIL release_wr got %b want 1", wr); end
        compared++; if (bus.imem_addr !== 10'h6) begin mismatched++; $display("FAIL release_addr got %h want 6", bus.imem_addr); end
        tick();
        compared++; if (instr !== 32'h106) begin mismatched++; $display("FAIL after_release_instr got %h want 106", instr); end
    endtask

    task automatic test_branch();
        pc_write = 1'b0;
        tick();
        compared++; if (wr !== 1'b0) begin mismatched++; $display("FAIL hold_wr got %b want 0", wr); end
        br = 1'b1; br_tgt = 10'h2A0;
        tick();
        compared++; if (instr !== 32'h0) begin mismatched++; $display("FAIL flush_hold_instr got %h want 0", instr); end
        compared++; if (pcp1 !== 10'h2A0) begin mismatched++; $display("FAIL flush_hold_pcp1 got %h want 2a0", pcp1); end
        compared++; if (wr !== 1'b1) begin mismatched++; $display("FAIL flush_hold_wr got %b want 1", wr); end
        compared++; if (bus.imem_addr !== 10'h2A0) begin mismatched++; $display("FAIL flush_hold_addr got %h want 2a0", bus.imem_addr); end
        br = 1'b0; pc_write = 1'b1;
        tick();
        compared++; if (instr !== 32'h3A0) begin mismatched++; $display("FAIL target_instr got %h want 3a0", instr); end
        compared++; if (pcp1 !== 10'h2A1) begin mismatched++; $display("FAIL target_pcp1 got %h want 2a1", pcp1); end
        br = 1'b1; br_tgt = 10'h3FE;
        tick();
        br = 1'b0;
        compared++; if (instr !== 32'h0) begin mismatched++; $display("FAIL flush_fetch_instr got %h want 0", instr); end
        compared++; if (pcp1 !== 10'h3FE) begin mismatched++; $display("FAIL flush_fetch_pcp1 got %h want 3fe", pcp1); end
        compared++; if (wr !== 1'b1) begin mismatched++; $display("FAIL flush_fetch_wr got %b want 1", wr); end
    endtask

    task automatic test_wrap();
        tick();
        compared++; if (pcp1 !== 10'h3FF) begin mismatched++; $display("FAIL wrap_pre_pcp1 got %h want 3ff", pcp1); end
        tick();
        compared++; if (instr !== 32'h4FF) begin mismatched++; $display("FAIL wrap_instr got %h want 4ff", instr); end
        compared++; if (pcp1 !== 10'h0) begin mismatched++; $display("FAIL wrap_pcp1 got %h want 0", pcp1); end
        compared++; if (bus.imem_addr !== 10'h0) begin mismatched++; $display("FAIL wrap_addr got %h want 0", bus.imem_addr); end
        tick();
        compared++; if (instr !== 32'h100) begin mismatched++; $display("FAIL wrap_next_instr got %h want 100", instr); end
    endtask

    task automatic test_reset_mid_fetch();
        lat = 3;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        compared++; if (wr !== 1'b0) begin mismatched++; $display("FAIL midreset_wr got %b want 0", wr); end
        compared++; if (bus.imem_addr !== 10'h0) begin mismatched++; $display("FAIL midreset_pc got %h want 0", bus.imem_addr); end
        br = 1'b1; br_tgt = 10'h010; force_rdy = 1'b1;
        tick();
        br = 1'b0; force_rdy = 1'b0; lat = 0;
        compared++; if (wr !== 1'b0) begin mismatched++; $display("FAIL idle_branch_wr got %b want 0", wr); end
        compared++; if (bus.imem_addr !== 10'h010) begin mismatched++; $display("FAIL idle_branch_addr got %h want 010", bus.imem_addr); end
        tick();
        compared++; if (instr !== 32'h110) begin mismatched++; $display("FAIL idle_branch_instr got %h want 110", instr); end
        compared++; if (pcp1 !== 10'h011) begin mismatched++; $display("FAIL idle_branch_pcp1 got %h want 011", pcp1); end
    endtask

    task automatic test_halt();
        rst = 1'b1; halt_on = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        repeat (3) tick();
        compared++; if (instr !== 32'h102) begin mismatched++; $display("FAIL halt_pre_instr got %h want 102", instr); end
        tick();
        compared++; if (instr !== 32'hFC00_0000) begin mismatched++; $display("FAIL halt_instr got %h want fc000000", instr); end
        compared++; if (pcp1 !== 10'h4) begin mismatched++; $display("FAIL halt_pcp1 got %h want 4", pcp1); end
        compared++; if (wr !== 1'b1) begin mismatched++; $display("FAIL halt_wr got %b want 1", wr); end
`ifdef FETCH_HALT_EN
        br = 1'b1; br_tgt = 10'h155;
        for (int i = 0; i < 3; i++) begin
            tick();
            compared++; if (halted !== 1'b1) begin mismatched++; $display("FAIL halted%0d got %b want 1", i, halted); end
            compared++; if (bus.imem_req !== 1'b0) begin mismatched++; $display("FAIL halted_req%0d got %b want 0", i, bus.imem_req); end
            compared++; if (wr !== 1'b0) begin mismatched++; $display("FAIL halted_wr%0d got %b want 0", i, wr); end
            compared++; if (bus.imem_addr !== 10'h4) begin mismatched++; $display("FAIL halted_pc%0d got %h want 4", i, bus.imem_addr); end
        end
        br = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        compared++; if (halted !== 1'b0) begin mismatched++; $display("FAIL unhalt got %b want 0", halted); end
        compared++; if (bus.imem_addr !== 10'h0) begin mismatched++; $display("FAIL unhalt_pc got %h want 0", bus.imem_addr); end
        tick();
        compared++; if (bus.imem_req !== 1'b1) begin mismatched++; $display("FAIL unhalt_req got %b want 1", bus.imem_req); end
`else
        compared++; if (halted !== 1'b0) begin mismatched++; $display("FAIL nohalt got %b want 0", halted); end
        compared++; if (bus.imem_req !== 1'b1) begin mismatched++; $display("FAIL nohalt_req got %b want 1", bus.imem_req); end
        tick();
        compared++; if (instr !== 32'h104) begin mismatched++; $display("FAIL nohalt_next got %h want 104", instr); end
        compared++; if (pcp1 !== 10'h5) begin mismatched++; $display("FAIL nohalt_pcp1 got %h want 5", pcp1); end
`endif
        halt_on = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_slow_mem();
        test_stall();
        test_branch();
        test_wrap();
        test_reset_mid_fetch();
        test_halt();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
